serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the single-bit full_adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through a CHUNK-bit ripple slice with a registered carry between chunks.
- Uses a start/done handshake and reports carry-out and signed overflow.
- Used wherever wide arithmetic is needed at low area and latency is not critical.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 2.
- CHUNK, 4: bits processed per cycle. Must divide WIDTH exactly; CHUNK = WIDTH is legal (single-cycle RUN).
- CYCLES, WIDTH/CHUNK: derived, not overridable. Number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = add, 1 = subtract; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- cin  input  1  add: carry-in; sub: borrow-in; latched with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result; updated only on entry to DONE
- carry  output  1  carry out of the MSB (sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow of the result

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; busy, done, carry, overflow = 0; sum = 0.
  - Internal shift registers, chunk counter and carry flop are cleared.
  - Reset asserted mid-operation aborts it: no done pulse, and sum returns to 0.
- Arithmetic:
  - Add: sum = a + b + cin.
  - Sub: sum = a + ~b + ~cin, i.e. a − b − cin.
  - The carry flop is seeded with cin ^ sub; B is inverted at latch time when sub = 1.
  - carry = carry out of bit WIDTH−1.
  - overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - All results are modulo 2^WIDTH.
- FSM (IDLE, RUN, DONE):
  - IDLE:
    - On start = 1: latch a, b (inverted if sub) and seed the carry flop; clear the counter; go to RUN.
    - busy goes high on the same edge.
  - RUN:
    - Each edge adds the low CHUNK bits of the A/B shift registers plus the carry flop.
    - The CHUNK result bits shift into the result register from the MSB end, A/B shift right by CHUNK, and the carry flop takes the slice carry-out.
    - The counter increments on each edge.
    - On the CYCLES-th RUN edge: drive sum, carry and overflow from the final values; done = 1; busy = 0; go to DONE.
  - DONE:
    - done = 1 for exactly this one cycle.
    - On the next edge, if start = 1, behave as IDLE with start (back-to-back, done drops, busy rises); otherwise go to IDLE.
- Latency:
  - done is high in the cycle following the CYCLES-th edge after the edge that sampled start (4 edges for the defaults).
  - Throughput: one result per CYCLES+1 cycles.
- Boundary conditions:
  - start while busy: ignored, no effect on the in-flight operation or its latched operands.
  - Changes to a, b, sub or cin after the sampling edge do not affect the result.
  - sum, carry and overflow hold their values from done until the next entry to DONE.
  - Counter wrap: the counter is reset on every accept and never exceeds CYCLES−1.

Test Plan (WIDTH = 16, CHUNK = 4):
1. a=0x1234, b=0x4321, sub=0, cin=0, start 1 cycle → busy high 4 cycles; done on the 4th edge after sampling; sum=0x5555, carry=0, overflow=0.
2. a=0xFFFF, b=0x0001, add → sum=0x0000, carry=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, carry=0, overflow=1.
3. a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, carry=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, carry=1, overflow=1.
4. a=0x000F, b=0x0001, cin=1, add → sum=0x0011. Changing a to 0xFFFF while busy leaves the result unchanged.
5. Pulse start again at RUN cycle 2 with different operands → ignored: exactly one done, with the original result. Hold start high through DONE with new operands → accepted back-to-back, and the second done arrives 5 cycles after the first.
6. Assert rst asynchronously, mid-clock, during RUN cycle 3 → busy, done and sum go to 0 immediately; no done pulse. Start again after release → correct result.

Source files
------------

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Multi-cycle add/subtract, CHUNK bits per clock through a ripple
//               slice with a registered inter-chunk carry; start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int CYCLES = WIDTH / CHUNK;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CYCLES - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;

    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_res_next;
    logic             w_cmsb;
    logic             w_ov;

    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_c};

    // Result bits enter at the MSB end so the final chunk lands in the top bits.
    assign w_res_next = (r_res >> CHUNK) | (WIDTH'(w_slice[CHUNK-1:0]) << (WIDTH - CHUNK));

    // On the last chunk the slice MSB is the word MSB; recover its carry-in.
    assign w_cmsb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];
    assign w_ov   = w_cmsb ^ w_slice[CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_run: begin
                    r_a   <= r_a >> CHUNK;
                    r_b   <= r_b >> CHUNK;
                    r_res <= w_res_next;
                    r_c   <= w_slice[CHUNK];
                    if (r_cnt == c_last) begin
                        r_cnt    <= '0;
                        sum      <= w_res_next;
                        carry    <= w_slice[CHUNK];
                        overflow <= w_ov;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= c_done;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= cin ^ sub;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_run;
                    end else begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int CYCLES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {overflow, carry, sum} straight from the arithmetic definition.
    function automatic logic [WIDTH+1:0] predict(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic s, input logic ci);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] r;
        logic             cy;
        logic             ov;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
            r    = full[WIDTH-1:0];
            cy   = full[WIDTH];
            ov   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else begin
            r  = x - y - WIDTH'(ci);
            cy = ({1'b0, x} >= ({1'b0, y} + (WIDTH+1)'(ci)));
            ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end
        return {ov, cy, r};
    endfunction

    // Behavioural model: a countdown of remaining cycles plus the pending answer.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             m_carry = 1'b0;
    logic             m_ov = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic [WIDTH+1:0] m_pend = '0;
    int               m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_carry <= 1'b0; m_ov <= 1'b0;
            m_sum <= '0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_sum   <= m_pend[WIDTH-1:0];
                m_carry <= m_pend[WIDTH];
                m_ov    <= m_pend[WIDTH+1];
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= predict(a, b, sub, cin);
                m_left <= CYCLES;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", WIDTH'(busy), WIDTH'(m_busy));
            check("done", WIDTH'(done), WIDTH'(m_done));
            check("sum", sum, m_sum);
            check("carry", WIDTH'(carry), WIDTH'(m_carry));
            check("overflow", WIDTH'(overflow), WIDTH'(m_ov));
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                          input logic ci, input logic [WIDTH-1:0] a_after,
                          output int lat, output int nbusy);
        @(negedge clk);
        a = x; b = y; sub = s; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = a_after; b = ~y; sub = ~s; cin = ~ci;
        lat   = 0;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end
        check("done seen", WIDTH'(done), WIDTH'(1'b1));
    endtask

    task automatic expect_result(input string name, input logic [WIDTH-1:0] s_exp,
                                 input logic c_exp, input logic o_exp);
        check({name, " sum"}, sum, s_exp);
        check({name, " carry"}, WIDTH'(carry), WIDTH'(c_exp));
        check({name, " overflow"}, WIDTH'(overflow), WIDTH'(o_exp));
    endtask

    initial begin
        int lat;
        int nbusy;
        int ndone;

        #1;
        check("reset busy", WIDTH'(busy), '0);
        check("reset done", WIDTH'(done), '0);
        check("reset sum", sum, '0);
        check("reset carry", WIDTH'(carry), '0);
        check("reset overflow", WIDTH'(overflow), '0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'hAAAA, lat, nbusy);
        check("t1 latency", WIDTH'(lat), WIDTH'(4));
        check("t1 busy cycles", WIDTH'(nbusy), WIDTH'(4));
        expect_result("t1", 16'h5555, 1'b0, 1'b0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, lat, nbusy);
        expect_result("t2a", 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, lat, nbusy);
        expect_result("t2b", 16'h8000, 1'b0, 1'b1);

        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h1234, lat, nbusy);
        expect_result("t3a", 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h0000, lat, nbusy);
        expect_result("t3b", 16'h7FFF, 1'b1, 1'b1);

        run_op(16'h000F, 16'h0001, 1'b0, 1'b1, 16'hFFFF, lat, nbusy);
        expect_result("t4", 16'h0011, 1'b0, 1'b0);

        // Start pulse mid-RUN must be ignored.
        @(negedge clk);
        a = 16'h0100; b = 16'h0023; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h7777; b = 16'h1111; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t5 first done", WIDTH'(done), WIDTH'(1'b1));
        expect_result("t5a", 16'h0123, 1'b0, 1'b0);
        // Start held through DONE is accepted back-to-back.
        a = 16'h0F0F; b = 16'h0101; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("t5 done drops", WIDTH'(done), '0);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t5 back-to-back spacing", WIDTH'(lat), WIDTH'(CYCLES + 1));
        expect_result("t5b", 16'h0E0D, 1'b1, 1'b0);

        // Asynchronous reset in the middle of RUN cycle 3.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6 busy after rst", WIDTH'(busy), '0);
        check("t6 done after rst", WIDTH'(done), '0);
        check("t6 sum after rst", sum, '0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (CYCLES + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6 no done after abort", WIDTH'(ndone), '0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, lat, nbusy);
        expect_result("t6", 16'h3333, 1'b0, 1'b0);

        // Random traffic, including start while busy and operand churn.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: a = 16'h7FFF;
                1: a = 16'h8000;
                2: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = 16'h8000;
                2: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (CYCLES + 2) @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
